// File: rtl/serial_frame_tx.sv
// serial_frame_tx: parallel-to-serial frame transmitter (start, LSB-first data, optional even parity, stop bits)
module serial_frame_tx #(
  parameter int WIDTH     = 8,
  parameter int PARITY_EN = 1,
  parameter int STOP_BITS = 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DIN,
  input  logic             DIN_VALID,
  output logic             DIN_READY,
  output logic             SDO,
  output logic             SFRAME,
  output logic             BUSY,
  output logic             DONE,
  output logic [15:0]      FRAME_CNT
);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_d;
  logic [5:0] cnt, cnt_d;
  logic [WIDTH-1:0] sreg, sreg_d;
  logic par, par_d, xfer, last_data, last_stop;
  logic sdo_d, sframe_d, done_d, ready_d;
  logic [15:0] frame_cnt_d;
  assign xfer      = DIN_VALID && DIN_READY;
  assign last_data = cnt == 6'(WIDTH - 1);
  assign last_stop = cnt == 6'(STOP_BITS - 1);
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      cnt       <= '0;
      sreg      <= '0;
      par       <= 1'b0;
      SDO       <= 1'b1;
      SFRAME    <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      DIN_READY <= 1'b0;
      FRAME_CNT <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      sreg      <= sreg_d;
      par       <= par_d;
      SDO       <= sdo_d;
      SFRAME    <= sframe_d;
      BUSY      <= sframe_d;
      DONE      <= done_d;
      DIN_READY <= ready_d;
      FRAME_CNT <= frame_cnt_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    sreg_d  = sreg;
    par_d   = par;
    case (state)
      IDLE: if (xfer) begin
        state_d = START;
        sreg_d  = DIN;
        par_d   = ^DIN;
      end
      START: begin
        state_d = DATA;
        cnt_d   = '0;
        sreg_d  = sreg >> 1;
      end
      DATA: if (last_data) begin
        state_d = (PARITY_EN != 0) ? PARITY : STOP;
        cnt_d   = '0;
      end else begin
        cnt_d  = cnt + 6'd1;
        sreg_d = sreg >> 1;
      end
      PARITY: state_d = STOP;
      STOP: if (last_stop) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else cnt_d = cnt + 6'd1;
      default: state_d = IDLE;
    endcase
  end
  // Outputs are computed from the next state so each bit appears right after the edge that enters its state
  always_comb begin
    sdo_d       = state_d == START ? 1'b0 : state_d == DATA ? sreg[0] : state_d == PARITY ? par : 1'b1;
    sframe_d    = state_d != IDLE;
    done_d      = state == STOP && state_d == IDLE;
    ready_d     = state_d == IDLE;
    frame_cnt_d = FRAME_CNT + {15'd0, done_d};
  end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed table-driven bench for two serial_frame_tx configurations
module tb_serial_frame_tx;
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic v0 = 1'b0, v1 = 1'b0;
  logic r0, s0, f0, b0, d0, r1, s1, f1, b1, d1;
  logic [15:0] c0, c1;
  int checks = 0, failures = 0;

  serial_frame_tx u0 (.CLK(clk), .RST(rst), .DIN(din), .DIN_VALID(v0), .DIN_READY(r0),
    .SDO(s0), .SFRAME(f0), .BUSY(b0), .DONE(d0), .FRAME_CNT(c0));
  serial_frame_tx #(.WIDTH(8), .PARITY_EN(0), .STOP_BITS(2)) u1 (.CLK(clk), .RST(rst), .DIN(din),
    .DIN_VALID(v1), .DIN_READY(r1), .SDO(s1), .SFRAME(f1), .BUSY(b1), .DONE(d1), .FRAME_CNT(c1));

  always #5 clk = ~clk;

  typedef struct {
    int          sel;
    logic [7:0]  d;
    logic [10:0] bits;
    logic [15:0] cnt;
  } vec_t;
  vec_t tv[11];

  function automatic logic rdy(int s);  return s != 0 ? r1 : r0; endfunction
  function automatic logic sdo(int s);  return s != 0 ? s1 : s0; endfunction
  function automatic logic sfr(int s);  return s != 0 ? f1 : f0; endfunction
  function automatic logic bsy(int s);  return s != 0 ? b1 : b0; endfunction
  function automatic logic dn(int s);   return s != 0 ? d1 : d0; endfunction
  function automatic logic [15:0] fc(int s); return s != 0 ? c1 : c0; endfunction

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic setv(int s, logic v);
    if (s != 0) v1 = v; else v0 = v;
  endtask

  task automatic do_reset();
    @(negedge clk) rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic xfer(int s, logic [7:0] d);
    int n = 0;
    @(negedge clk);
    din = d;
    setv(s, 1'b1);
    while (!rdy(s) && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (n == 40) chk("ready_timeout", 0, 1);
    @(posedge clk);
  endtask

  task automatic rx(int s, logic keep, logic [7:0] nd, output logic [10:0] bits, output logic sf_all, output logic quiet);
    bits = '0;
    sf_all = 1'b1;
    quiet = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 0) begin
        if (!keep) setv(s, 1'b0);
        din = nd;
      end
      bits = {bits[9:0], sdo(s)};
      sf_all &= sfr(s);
      quiet &= bsy(s) && !dn(s);
    end
  endtask

  task automatic check_done(int s, logic [15:0] ec, string nm);
    chk({nm, "_done"}, {31'd0, dn(s)}, 1);
    chk({nm, "_done_sdo"}, {31'd0, sdo(s)}, 1);
    chk({nm, "_done_sframe"}, {31'd0, sfr(s)}, 0);
    chk({nm, "_done_busy"}, {31'd0, bsy(s)}, 0);
    chk({nm, "_done_ready"}, {31'd0, rdy(s)}, 1);
    chk({nm, "_cnt"}, {16'd0, fc(s)}, {16'd0, ec});
  endtask

  task automatic send(int s, logic [7:0] d, logic [10:0] eb, logic [15:0] ec, string nm);
    logic [10:0] bits;
    logic sfa, q;
    xfer(s, d);
    rx(s, 1'b0, ~d, bits, sfa, q);
    chk({nm, "_bits"}, {21'd0, bits}, {21'd0, eb});
    chk({nm, "_sframe"}, {31'd0, sfa}, 1);
    chk({nm, "_busy_nodone"}, {31'd0, q}, 1);
    @(negedge clk);
    check_done(s, ec, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [10:0] bits;
    logic sfa, q;
    tv[0]  = '{0, 8'hA5, 11'b01010010101, 16'd1};
    tv[1]  = '{0, 8'h01, 11'b01000000011, 16'd2};
    tv[2]  = '{0, 8'h3C, 11'b00011110001, 16'd3};
    tv[3]  = '{0, 8'hC3, 11'b01100001101, 16'd4};
    tv[4]  = '{1, 8'h01, 11'b01000000011, 16'd1};
    tv[5]  = '{0, 8'hFF, 11'b01111111101, 16'd5};
    tv[6]  = '{1, 8'h03, 11'b01100000011, 16'd2};
    tv[7]  = '{0, 8'h00, 11'b00000000001, 16'd6};
    tv[8]  = '{0, 8'h80, 11'b00000000111, 16'd7};
    tv[9]  = '{1, 8'hFE, 11'b00111111111, 16'd3};
    tv[10] = '{0, 8'h03, 11'b01100000001, 16'd8};

    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("rst_ready_first", {31'd0, r0}, 0);
    chk("rst_sdo", {31'd0, s0}, 1);
    chk("rst_sframe", {31'd0, f0}, 0);
    chk("rst_busy", {31'd0, b0}, 0);
    chk("rst_done", {31'd0, d0}, 0);
    chk("rst_cnt", {16'd0, c0}, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_ready", {31'd0, r0}, 1);
      chk("idle_sdo_sframe", {30'd0, s0, f0}, 2);
    end

    foreach (tv[i]) send(tv[i].sel, tv[i].d, tv[i].bits, tv[i].cnt, $sformatf("vec%0d", i));

    do_reset();
    xfer(0, 8'h3C);
    rx(0, 1'b1, 8'hC3, bits, sfa, q);
    chk("b2b_first_bits", {21'd0, bits}, {21'd0, 11'b00011110001});
    @(negedge clk);
    check_done(0, 16'd1, "b2b_gap");
    rx(0, 1'b0, 8'h55, bits, sfa, q);
    chk("b2b_second_bits", {21'd0, bits}, {21'd0, 11'b01100001101});
    chk("b2b_second_sframe", {31'd0, sfa}, 1);
    @(negedge clk);
    check_done(0, 16'd2, "b2b_end");

    xfer(0, 8'hA5);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) v0 = 1'b0;
    end
    chk("abort_bit3", {31'd0, s0}, 0);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    chk("abort_sdo", {31'd0, s0}, 1);
    chk("abort_sframe", {31'd0, f0}, 0);
    chk("abort_busy", {31'd0, b0}, 0);
    chk("abort_done", {31'd0, d0}, 0);
    chk("abort_cnt", {16'd0, c0}, 0);
    chk("abort_ready", {31'd0, r0}, 0);
    send(0, 8'hA5, 11'b01010010101, 16'd1, "after_abort");

    @(negedge clk) force u0.FRAME_CNT = 16'hFFFF;
    @(negedge clk) release u0.FRAME_CNT;
    @(negedge clk);
    chk("wrap_preload", {16'd0, c0}, 32'h0000FFFF);
    send(0, 8'h01, 11'b01000000011, 16'h0000, "wrap");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
